// File: rtl/parity_gen_chk_stream_if.sv
// Valid/ready bundle for parity_gen_chk_stream: the incoming beat with its received
// parity bit, and the registered outgoing beat with generated parity and error flag.
interface parity_gen_chk_stream_if #(
   parameter int DATA_W = 8
);
   // Handshake: a beat moves on a rising edge where valid && ready are both high.
   // A producer holding valid high keeps its payload stable until that edge, and a
   // consumer may drive ready independently of valid.
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_parity;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic              out_parity;
   logic              out_error;

   modport master (
      output in_valid,
      output in_data,
      output in_parity,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_parity,
      input  out_error
   );

   modport slave (
      input  in_valid,
      input  in_data,
      input  in_parity,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_parity,
      output out_error
   );
endinterface

// File: rtl/parity_gen_chk_stream.sv
// Registered parity generator/checker on a valid/ready stream, with a sticky error
// flag and a saturating error counter for status readout.
module parity_gen_chk_stream #(
   parameter int DATA_W = 8,
   parameter int ODD    = 0,
   parameter int CNT_W  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   parity_gen_chk_stream_if.slave bus,
   input  logic                  chk_en,
   input  logic                  clr_err,
   output logic                  err_sticky,
   output logic [CNT_W-1:0]      err_count
);

   localparam logic             ODD_BIT = (ODD != 0);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic              valid_q,  valid_d;
   logic [DATA_W-1:0] data_q,   data_d;
   logic              par_q,    par_d;
   logic              err_q,    err_d;
   logic              sticky_q, sticky_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;

   logic in_ready;
   logic accept;
   logic xfer;
   logic gen_par;
   logic mismatch;
   logic err_hit;

   // The slot frees when empty or when its beat leaves this cycle.
   assign in_ready = !valid_q || bus.out_ready;
   assign accept   = bus.in_valid && in_ready;
   assign xfer     = valid_q && bus.out_ready;

   assign gen_par  = (^bus.in_data) ^ ODD_BIT;
   assign mismatch = (^{bus.in_parity, bus.in_data}) ^ ODD_BIT;
   assign err_hit  = accept && chk_en && mismatch;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      par_d   = par_q;
      err_d   = err_q;
      if (accept) begin
         valid_d = 1'b1;
         data_d  = bus.in_data;
         par_d   = gen_par;
         err_d   = chk_en && mismatch;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   // A clear and a new error on the same edge leave exactly that one error recorded.
   always_comb begin
      cnt_d    = cnt_q;
      sticky_d = sticky_q;
      if (clr_err) begin
         cnt_d    = err_hit ? CNT_ONE : '0;
         sticky_d = err_hit;
      end else if (err_hit) begin
         sticky_d = 1'b1;
         if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         data_q   <= '0;
         par_q    <= 1'b0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         valid_q  <= valid_d;
         data_q   <= data_d;
         par_q    <= par_d;
         err_q    <= err_d;
         sticky_q <= sticky_d;
         cnt_q    <= cnt_d;
      end
   end

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = valid_q;
   assign bus.out_data   = data_q;
   assign bus.out_parity = par_q;
   assign bus.out_error  = err_q;
   assign err_sticky     = sticky_q;
   assign err_count      = cnt_q;

   a_stall_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (valid_q && !bus.out_ready) |=>
         (valid_q && $stable(data_q) && $stable(par_q) && $stable(err_q)));

   a_cnt_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
      (!clr_err && cnt_q == CNT_MAX) |=> (cnt_q == CNT_MAX));

   a_sticky_tracks_cnt: assert property (@(posedge clk) disable iff (!rst_n)
      (cnt_q != '0) |-> sticky_q);

endmodule
